// File: rtl/jt12_syn_if.sv
// Synthesizer-side end of the CPU write handshake: four-phase busy, register strobes, timer flags and IRQ.
// Strobe one cycle after acceptance; busy holds at least BUSY_CYCLES+1 cycles and never drops while write is high.
module jt12_syn_if #(
  parameter int BUSY_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       write_i,
  input  logic [1:0] addr_i,
  input  logic [7:0] din_i,
  output logic       busy_o,
  output logic       reg_wr_o,
  output logic       reg_part_o,
  output logic [7:0] reg_addr_o,
  output logic [7:0] reg_din_o,
  input  logic       ovf_a_i,
  input  logic       ovf_b_i,
  output logic       load_a_o,
  output logic       load_b_o,
  output logic       flag_a_o,
  output logic       flag_b_o,
  output logic       irq_n_o
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD, RELEASE} state_t;

  localparam logic [5:0] CNT_INIT = 6'(BUSY_CYCLES - 1);

  state_t     state_q, state_d;
  logic       armed_q, armed_d;
  logic       busy_q, busy_d;
  logic [5:0] cnt_q, cnt_d;
  logic [1:0] cap_addr_q, cap_addr_d;
  logic [7:0] cap_din_q, cap_din_d;
  logic [7:0] latch_q, latch_d;
  logic       reg_wr_q, reg_wr_d;
  logic       reg_part_q, reg_part_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_din_q, reg_din_d;
  logic       load_a_q, load_a_d, load_b_q, load_b_d;
  logic       en_a_q, en_a_d, en_b_q, en_b_d;
  logic       flag_a_q, flag_a_d, flag_b_q, flag_b_d;
  logic       irq_n_q, irq_n_d;
  logic       clr_a, clr_b;

  always_comb begin
    state_d    = state_q;
    // A level still high across reset must be seen low once before it counts.
    armed_d    = armed_q | ~write_i;
    busy_d     = busy_q;
    cnt_d      = cnt_q;
    cap_addr_d = cap_addr_q;
    cap_din_d  = cap_din_q;
    latch_d    = latch_q;
    reg_wr_d   = 1'b0;
    reg_part_d = reg_part_q;
    reg_addr_d = reg_addr_q;
    reg_din_d  = reg_din_q;
    load_a_d   = load_a_q;
    load_b_d   = load_b_q;
    en_a_d     = en_a_q;
    en_b_d     = en_b_q;
    clr_a      = 1'b0;
    clr_b      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (write_i && armed_q) begin
          cap_addr_d = addr_i;
          cap_din_d  = din_i;
          busy_d     = 1'b1;
          cnt_d      = CNT_INIT;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        state_d = HOLD;
        // EXEC counts toward the busy time so busy spans exactly BUSY_CYCLES+1.
        if (cnt_q != 6'd0) cnt_d = cnt_q - 6'd1;
        if (!cap_addr_q[0]) begin
          latch_d = cap_din_q;
        end else begin
          reg_wr_d   = 1'b1;
          reg_part_d = cap_addr_q[1];
          reg_addr_d = latch_q;
          reg_din_d  = cap_din_q;
          if (!cap_addr_q[1] && latch_q == 8'h27) begin
            load_a_d = cap_din_q[0];
            load_b_d = cap_din_q[1];
            en_a_d   = cap_din_q[2];
            en_b_d   = cap_din_q[3];
            clr_a    = cap_din_q[4];
            clr_b    = cap_din_q[5];
          end
        end
      end
      HOLD: begin
        if (cnt_q == 6'd0) state_d = RELEASE;
        else               cnt_d   = cnt_q - 6'd1;
      end
      RELEASE: begin
        if (!write_i) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Overflow set beats a simultaneous clear.
  assign flag_a_d = ovf_a_i | (flag_a_q & ~clr_a);
  assign flag_b_d = ovf_b_i | (flag_b_q & ~clr_b);
  assign irq_n_d  = ~((flag_a_q & en_a_q) | (flag_b_q & en_b_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      armed_q    <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q      <= 6'd0;
      cap_addr_q <= 2'd0;
      cap_din_q  <= 8'h00;
      latch_q    <= 8'h00;
      reg_wr_q   <= 1'b0;
      reg_part_q <= 1'b0;
      reg_addr_q <= 8'h00;
      reg_din_q  <= 8'h00;
      load_a_q   <= 1'b0;
      load_b_q   <= 1'b0;
      en_a_q     <= 1'b0;
      en_b_q     <= 1'b0;
      flag_a_q   <= 1'b0;
      flag_b_q   <= 1'b0;
      irq_n_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      cap_addr_q <= cap_addr_d;
      cap_din_q  <= cap_din_d;
      latch_q    <= latch_d;
      reg_wr_q   <= reg_wr_d;
      reg_part_q <= reg_part_d;
      reg_addr_q <= reg_addr_d;
      reg_din_q  <= reg_din_d;
      load_a_q   <= load_a_d;
      load_b_q   <= load_b_d;
      en_a_q     <= en_a_d;
      en_b_q     <= en_b_d;
      flag_a_q   <= flag_a_d;
      flag_b_q   <= flag_b_d;
      irq_n_q    <= irq_n_d;
    end
  end

  assign busy_o     = busy_q;
  assign reg_wr_o   = reg_wr_q;
  assign reg_part_o = reg_part_q;
  assign reg_addr_o = reg_addr_q;
  assign reg_din_o  = reg_din_q;
  assign load_a_o   = load_a_q;
  assign load_b_o   = load_b_q;
  assign flag_a_o   = flag_a_q;
  assign flag_b_o   = flag_b_q;
  assign irq_n_o    = irq_n_q;

endmodule

// File: tb/tb_jt12_syn_if.sv
// Directed bench for jt12_syn_if: handshake timing, strobes, reg 0x27 side effects and mid-access reset.
module tb_jt12_syn_if;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       write_i = 1'b0;
  logic [1:0] addr_i = 2'd0;
  logic [7:0] din_i = 8'h00;
  logic       ovf_a_i = 1'b0;
  logic       ovf_b_i = 1'b0;
  logic       busy_o, reg_wr_o, reg_part_o;
  logic [7:0] reg_addr_o, reg_din_o;
  logic       load_a_o, load_b_o, flag_a_o, flag_b_o, irq_n_o;

  int n_tests = 0;
  int n_fail  = 0;

  jt12_syn_if #(.BUSY_CYCLES(32)) dut (
    .clk(clk), .rst_n(rst_n), .write_i(write_i), .addr_i(addr_i), .din_i(din_i),
    .busy_o(busy_o), .reg_wr_o(reg_wr_o), .reg_part_o(reg_part_o),
    .reg_addr_o(reg_addr_o), .reg_din_o(reg_din_o),
    .ovf_a_i(ovf_a_i), .ovf_b_i(ovf_b_i),
    .load_a_o(load_a_o), .load_b_o(load_b_o),
    .flag_a_o(flag_a_o), .flag_b_o(flag_b_o), .irq_n_o(irq_n_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One access: write held for hold_cyc sampled edges, optional ovf_b pulse timed to the EXEC edge.
  task automatic access(input logic [1:0] a, input logic [7:0] d, input int hold_cyc, input bit ovfb,
                        output int busy_len, output int strb, output bit wr_at1);
    bit done;
    done = 1'b0;
    busy_len = 0;
    strb = 0;
    wr_at1 = 1'b0;
    @(negedge clk);
    write_i = 1'b1;
    addr_i  = a;
    din_i   = d;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      if (ovfb) ovf_b_i = (c == 0);
      if (c + 1 >= hold_cyc) write_i = 1'b0;
      if (reg_wr_o) strb++;
      if (c == 1) wr_at1 = reg_wr_o;
      if (busy_o) busy_len++;
      else begin
        done = 1'b1;
        break;
      end
    end
    ovf_b_i = 1'b0;
    if (!done) chk("access_timeout", 32'd0, 32'd1);
  endtask

  int  bl, st, bl0;
  bit  w1;

  initial begin
    // Reset state
    #12;
    chk("rst_busy", busy_o, 0);
    chk("rst_reg_wr", reg_wr_o, 0);
    chk("rst_reg_part", reg_part_o, 0);
    chk("rst_reg_addr", reg_addr_o, 8'h00);
    chk("rst_reg_din", reg_din_o, 8'h00);
    chk("rst_load", {load_a_o, load_b_o}, 2'b00);
    chk("rst_flags", {flag_a_o, flag_b_o}, 2'b00);
    chk("rst_irq_n", irq_n_o, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Address 0x28 then data 0xF0
    access(2'd0, 8'h28, 1, 1'b0, bl, st, w1);
    chk("aw_busy_len", bl, 33);
    chk("aw_no_strobe", st, 0);
    access(2'd1, 8'hF0, 1, 1'b0, bl, st, w1);
    chk("dw_busy_len", bl, 33);
    chk("dw_strobes", st, 1);
    chk("dw_strobe_time", w1, 1);
    chk("dw_part", reg_part_o, 0);
    chk("dw_addr", reg_addr_o, 8'h28);
    chk("dw_din", reg_din_o, 8'hF0);

    // Part 1: address 0xA4, data 0x11 then 0x22
    access(2'd2, 8'hA4, 1, 1'b0, bl, st, w1);
    chk("p1_aw_no_strobe", st, 0);
    access(2'd3, 8'h11, 1, 1'b0, bl, st, w1);
    chk("p1_d1_strobes", st, 1);
    chk("p1_d1_part", reg_part_o, 1);
    chk("p1_d1_addr", reg_addr_o, 8'hA4);
    chk("p1_d1_din", reg_din_o, 8'h11);
    access(2'd3, 8'h22, 1, 1'b0, bl, st, w1);
    chk("p1_d2_strobes", st, 1);
    chk("p1_d2_addr", reg_addr_o, 8'hA4);
    chk("p1_d2_din", reg_din_o, 8'h22);

    // Write held for 100 sampled edges
    access(2'd3, 8'h33, 100, 1'b0, bl, st, w1);
    chk("long_busy_len", bl, 100);
    chk("long_strobes", st, 1);

    // Reg 0x27 = 0x0D: load_A, enA, enB
    access(2'd0, 8'h27, 1, 1'b0, bl, st, w1);
    access(2'd1, 8'h0D, 1, 1'b0, bl, st, w1);
    chk("r27_strobe", st, 1);
    chk("r27_load", {load_a_o, load_b_o}, 2'b10);
    chk("r27_irq_idle", irq_n_o, 1);
    @(negedge clk); ovf_a_i = 1'b1;
    @(negedge clk); ovf_a_i = 1'b0;
    @(posedge clk); #1;
    chk("ovfa_flag", flag_a_o, 1);
    chk("ovfa_irq_n", irq_n_o, 0);
    access(2'd1, 8'h1C, 1, 1'b0, bl, st, w1);
    chk("clra_flag", flag_a_o, 0);
    chk("clra_irq_n", irq_n_o, 1);
    chk("clra_load", {load_a_o, load_b_o}, 2'b00);

    // Clear B coinciding with an ovf_B pulse: set wins
    access(2'd1, 8'h2C, 1, 1'b1, bl, st, w1);
    chk("setwins_flag_b", flag_b_o, 1);
    chk("setwins_irq_n", irq_n_o, 0);

    // Part 1 0x27 is forwarded only
    access(2'd2, 8'h27, 1, 1'b0, bl, st, w1);
    access(2'd3, 8'hFF, 1, 1'b0, bl, st, w1);
    chk("p1r27_strobe", st, 1);
    chk("p1r27_part", reg_part_o, 1);
    chk("p1r27_addr", reg_addr_o, 8'h27);
    chk("p1r27_load", {load_a_o, load_b_o}, 2'b00);
    chk("p1r27_flags", {flag_a_o, flag_b_o}, 2'b01);
    chk("p1r27_irq_n", irq_n_o, 0);

    // Reset during HOLD with write held high
    @(negedge clk);
    write_i = 1'b1; addr_i = 2'd1; din_i = 8'h55;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_busy", busy_o, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy_o, 0);
    chk("midrst_flags", {flag_a_o, flag_b_o}, 2'b00);
    chk("midrst_irq_n", irq_n_o, 1);
    @(negedge clk);
    rst_n = 1'b1;
    bl0 = 0;
    st = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (busy_o) bl0++;
      if (reg_wr_o) st++;
    end
    chk("held_write_busy", bl0, 0);
    chk("held_write_strobe", st, 0);
    @(negedge clk);
    write_i = 1'b0;
    repeat (2) @(posedge clk);
    access(2'd1, 8'h66, 1, 1'b0, bl, st, w1);
    chk("post_rst_busy_len", bl, 33);
    chk("post_rst_strobe", st, 1);
    chk("post_rst_addr", reg_addr_o, 8'h00);
    chk("post_rst_din", reg_din_o, 8'h66);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
